// File: rtl/wb_stream_wr.sv
// Wishbone write-master: drains a valid/ready word stream into consecutive word
// addresses, one single-word write per beat, and reports completion, short end or bus error.
module wb_stream_wr #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = 4,
    parameter int LEN_WIDTH    = 16,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    output logic [ADDR_WIDTH-1:0]   m_adr_o,
    output logic [DATA_WIDTH-1:0]   m_dat_o,
    output logic                    m_we_o,
    output logic [SELECT_WIDTH-1:0] m_sel_o,
    output logic                    m_stb_o,
    output logic                    m_cyc_o,
    input  logic                    m_ack_i,
    input  logic                    m_err_i,
    output logic                    busy,
    output logic                    done,
    output logic                    status_short,
    output logic                    status_err,
    output logic [LEN_WIDTH-1:0]    word_count
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(SELECT_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_STEP - ADDR_WIDTH'(1));

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;

    state_t                 state;
    state_t                 state_n;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   issued;
    logic [LEN_WIDTH-1:0]   issued_inc;
    logic [ADDR_WIDTH-1:0]  issue_addr;
    logic                   last_seen;
    logic                   short_flag;
    logic                   err_flag;
    logic [TMO_W-1:0]       tmo_cnt;

    logic cmd_fire;
    logic bus_ack;
    logic bus_err;
    logic tmo_hit;
    logic abort;
    logic room;
    logic beat;

    assign cmd_fire   = (state == IDLE) && cmd_ready && cmd_valid;
    assign bus_ack    = m_stb_o && m_ack_i && !m_err_i;
    assign bus_err    = m_stb_o && m_err_i;
    assign tmo_hit    = (TIMEOUT != 0) && m_stb_o && !m_ack_i && !m_err_i && (tmo_cnt == TMO_LAST);
    assign abort      = bus_err || tmo_hit;
    assign room       = (issued < len_q) && !last_seen;
    assign issued_inc = issued + LEN_WIDTH'(1);
    assign beat       = s_valid && s_ready;

    assign status_short = done && short_flag;
    assign status_err   = done && err_flag;

    // A beat may ride on the ack of the previous word so the strobe never drops;
    // an erroring or timed-out word must not admit a new beat.
    always_comb begin
        s_ready = 1'b0;
        case (state)
            RUN:     s_ready = room && (!m_stb_o || bus_ack);
            FLUSH:   s_ready = room;
            default: s_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    state_n = (cmd_len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = room ? FLUSH : FIN;
                end else if (bus_ack && !beat && !room) begin
                    state_n = FIN;
                end
            end
            FLUSH: begin
                if (!room) begin
                    state_n = FIN;
                end else if (beat && (s_last || (issued_inc == len_q))) begin
                    state_n = FIN;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            len_q      <= '0;
            issued     <= '0;
            issue_addr <= '0;
            last_seen  <= 1'b0;
            short_flag <= 1'b0;
            err_flag   <= 1'b0;
            tmo_cnt    <= '0;
            word_count <= '0;
            m_adr_o    <= '0;
            m_dat_o    <= '0;
            m_we_o     <= 1'b0;
            m_sel_o    <= '0;
            m_stb_o    <= 1'b0;
            m_cyc_o    <= 1'b0;
        end else begin
            cmd_ready <= (state_n == IDLE);
            busy      <= (state_n != IDLE);
            done      <= (state_n == FIN);

            if (cmd_fire) begin
                len_q      <= cmd_len;
                issue_addr <= cmd_addr & ALIGN_MASK;
                issued     <= '0;
                word_count <= '0;
                last_seen  <= 1'b0;
                short_flag <= 1'b0;
                err_flag   <= 1'b0;
            end

            if (beat) begin
                issued <= issued_inc;
                if (s_last) begin
                    last_seen  <= 1'b1;
                    short_flag <= (issued_inc != len_q);
                end
            end

            // issue_addr runs one word ahead of the bus; with a single outstanding
            // write this matches advancing the address on each ack.
            if ((state == RUN) && beat) begin
                m_adr_o    <= issue_addr;
                m_dat_o    <= s_data;
                issue_addr <= issue_addr + ADDR_STEP;
                m_we_o     <= 1'b1;
                m_sel_o    <= '1;
                m_stb_o    <= 1'b1;
                m_cyc_o    <= 1'b1;
                tmo_cnt    <= '0;
            end else if (bus_ack || abort) begin
                m_we_o  <= 1'b0;
                m_sel_o <= '0;
                m_stb_o <= 1'b0;
                m_cyc_o <= 1'b0;
            end else if (m_stb_o) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (bus_ack) begin
                word_count <= word_count + LEN_WIDTH'(1);
            end
            if (abort) begin
                err_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_stream_wr.sv
// Bench for wb_stream_wr: RAM-like Wishbone slave with error/no-ack modes, random
// stream gaps, and a transaction-level model of which words must land where.
module tb_wb_stream_wr;

    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int SW  = 4;
    localparam int LW  = 16;
    localparam int TMO = 16;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          s_last;
    logic [AW-1:0] m_adr_o;
    logic [DW-1:0] m_dat_o;
    logic          m_we_o;
    logic [SW-1:0] m_sel_o;
    logic          m_stb_o;
    logic          m_cyc_o;
    logic          m_ack_i;
    logic          m_err_i;
    logic          busy;
    logic          done;
    logic          status_short;
    logic          status_err;
    logic [LW-1:0] word_count;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem [0:(1 << (AW - 2)) - 1];
    int            slave_mode = 0;
    int            err_at_abs = 0;
    int            req_n = 0;

    logic [DW-1:0] src [0:31];
    logic [AW-1:0] wq_a [$];
    logic [DW-1:0] wq_d [$];
    int            stb_cycles, stb_falls, cyc_seen, ready_extra;
    int            last_ack_cyc, done_cyc, fire_cyc;
    bit            done_seen;
    logic          got_short, got_err;
    logic [LW-1:0] got_wc;

    int acks_mid;
    bit hit_mid;
    bit fire_mid;

    wb_stream_wr #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .SELECT_WIDTH(SW),
        .LEN_WIDTH   (LW),
        .TIMEOUT     (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_last      (s_last),
        .m_adr_o     (m_adr_o),
        .m_dat_o     (m_dat_o),
        .m_we_o      (m_we_o),
        .m_sel_o     (m_sel_o),
        .m_stb_o     (m_stb_o),
        .m_cyc_o     (m_cyc_o),
        .m_ack_i     (m_ack_i),
        .m_err_i     (m_err_i),
        .busy        (busy),
        .done        (done),
        .status_short(status_short),
        .status_err  (status_err),
        .word_count  (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port-RAM-like slave: responds one cycle after strobe, ignores strobe while
    // responding. Mode 1 never responds, mode 2 answers request err_at_abs with err.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ack_i <= 1'b0;
            m_err_i <= 1'b0;
        end else begin
            m_ack_i <= 1'b0;
            m_err_i <= 1'b0;
            if (m_cyc_o && m_stb_o && !m_ack_i && !m_err_i && slave_mode != 1) begin
                req_n <= req_n + 1;
                if (slave_mode == 2 && req_n + 1 == err_at_abs) begin
                    m_err_i <= 1'b1;
                end else begin
                    m_ack_i <= 1'b1;
                    if (m_we_o) mem[m_adr_o[AW-1:2]] <= m_dat_o;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input string tag, input logic [AW-1:0] addr, input int len,
                           input int last_pos, input int vprob, input int smode, input int serr_at);
        int            n, nw, nsrc, idx;
        bit            exp_err, exp_short, fire, acc, prev_stb;
        logic [AW-1:0] a;

        // Reference: words consumed, words written, and expected status.
        n = (last_pos >= 0 && last_pos + 1 < len) ? last_pos + 1 : len;
        if (smode == 1) begin
            nw = 0;
            exp_err = (n > 0);
        end else if (smode == 2 && serr_at <= n) begin
            nw = serr_at - 1;
            exp_err = 1'b1;
        end else begin
            nw = n;
            exp_err = 1'b0;
        end
        exp_short = (last_pos >= 0) && (last_pos + 1 < len);
        nsrc = (last_pos >= 0) ? last_pos + 1 : len + 2;
        for (int i = 0; i < 32; i++) src[i] = $urandom;

        wq_a.delete();
        wq_d.delete();
        stb_cycles = 0; stb_falls = 0; cyc_seen = 0; ready_extra = 0;
        last_ack_cyc = -100; done_cyc = -1; fire_cyc = -1;
        done_seen = 1'b0; got_short = 1'b0; got_err = 1'b0; got_wc = '0;
        prev_stb = 1'b0;
        idx = 0;

        @(negedge clk);
        slave_mode = smode;
        err_at_abs = req_n + serr_at;
        cmd_addr   = addr;
        cmd_len    = LW'(len);
        cmd_valid  = 1'b1;
        for (int cyc = 0; cyc < 600 && !done_seen; cyc++) begin
            s_valid = (idx < nsrc) && ($urandom_range(1, 100) <= vprob);
            s_data  = src[idx % 32];
            s_last  = (idx == last_pos);
            fire = cmd_valid && cmd_ready;
            if (fire) fire_cyc = cyc;
            acc = s_valid && s_ready;
            if (s_ready && idx >= n) ready_extra++;
            if (m_stb_o && m_ack_i) begin
                wq_a.push_back(m_adr_o);
                wq_d.push_back(m_dat_o);
                last_ack_cyc = cyc;
            end
            if (m_stb_o) stb_cycles++;
            if (prev_stb && !m_stb_o) stb_falls++;
            prev_stb = m_stb_o;
            if (m_cyc_o) cyc_seen = 1;
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                got_short = status_short;
                got_err   = status_err;
                got_wc    = word_count;
            end
            @(negedge clk);
            if (fire) cmd_valid = 1'b0;
            if (acc) idx++;
        end
        cmd_valid = 1'b0;
        s_valid   = 1'b0;
        s_last    = 1'b0;

        chk($sformatf("%s_done", tag), 64'(done_seen), 64'(1));
        chk($sformatf("%s_status_err", tag), 64'(got_err), 64'(exp_err));
        if (!exp_err) chk($sformatf("%s_status_short", tag), 64'(got_short), 64'(exp_short));
        chk($sformatf("%s_word_count", tag), 64'(got_wc), 64'(nw));
        chk($sformatf("%s_writes", tag), 64'(wq_a.size()), 64'(nw));
        chk($sformatf("%s_beats_taken", tag), 64'(idx), 64'(n));
        chk($sformatf("%s_ready_past_end", tag), 64'(ready_extra), 64'(0));
        for (int i = 0; i < nw && i < wq_a.size(); i++) begin
            a = (addr & 12'hFFC) + AW'(4 * i);
            chk($sformatf("%s_adr%0d", tag, i), 64'(wq_a[i]), 64'(a));
            chk($sformatf("%s_dat%0d", tag, i), 64'(wq_d[i]), 64'(src[i]));
            chk($sformatf("%s_ram%0d", tag, i), 64'(mem[a[AW-1:2]]), 64'(src[i]));
        end
        chk($sformatf("%s_cmd_ready_after", tag), 64'(cmd_ready), 64'(1));
        chk($sformatf("%s_busy_after", tag), 64'(busy), 64'(0));
    endtask

    initial begin
        rst_n = 1'b1;
        cmd_addr = '0; cmd_len = '0; cmd_valid = 1'b0;
        s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_stb", 64'(m_stb_o), 64'(0));
        chk("rst_cyc", 64'(m_cyc_o), 64'(0));
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_word_count", 64'(word_count), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready", 64'(cmd_ready), 64'(1));

        run_cmd("basic", 12'h100, 4, -1, 100, 0, 0);
        chk("basic_stb_cycles", 64'(stb_cycles), 64'(8));
        chk("basic_stb_falls", 64'(stb_falls), 64'(1));
        chk("basic_ack_to_done", 64'(done_cyc - last_ack_cyc), 64'(1));

        run_cmd("early", 12'h200, 8, 2, 100, 0, 0);

        run_cmd("zero", 12'h300, 0, -1, 100, 0, 0);
        chk("zero_no_cyc", 64'(cyc_seen), 64'(0));
        chk("zero_latency", 64'(done_cyc - fire_cyc), 64'(1));

        run_cmd("align", 12'h103, 1, -1, 100, 0, 0);
        run_cmd("wrap", 12'hFFC, 2, -1, 70, 0, 0);

        run_cmd("tmo", 12'h040, 4, 2, 100, 1, 0);
        chk("tmo_stb_cycles", 64'(stb_cycles), 64'(TMO));

        run_cmd("err", 12'h080, 4, -1, 100, 2, 2);

        // Reset while the second of four words is on the bus.
        @(negedge clk);
        slave_mode = 0;
        cmd_addr = 12'h400; cmd_len = LW'(4); cmd_valid = 1'b1;
        s_valid = 1'b1; s_data = 32'h5555_0000; s_last = 1'b0;
        acks_mid = 0; hit_mid = 1'b0;
        for (int cyc = 0; cyc < 50 && !hit_mid; cyc++) begin
            fire_mid = cmd_valid && cmd_ready;
            if (m_stb_o && m_ack_i) acks_mid++;
            else if (m_stb_o && acks_mid == 1) hit_mid = 1'b1;
            if (!hit_mid) begin
                @(negedge clk);
                if (fire_mid) cmd_valid = 1'b0;
            end
        end
        chk("mid_reached_word2", 64'(hit_mid), 64'(1));
        #2 rst_n = 1'b0;
        cmd_valid = 1'b0; s_valid = 1'b0;
        #1;
        chk("mid_rst_stb", 64'(m_stb_o), 64'(0));
        chk("mid_rst_cyc", 64'(m_cyc_o), 64'(0));
        chk("mid_rst_we", 64'(m_we_o), 64'(0));
        chk("mid_rst_adr", 64'(m_adr_o), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("mid_rst_s_ready", 64'(s_ready), 64'(0));
        chk("mid_rst_word_count", 64'(word_count), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd("after_rst", 12'h500, 3, -1, 100, 0, 0);

        for (int k = 0; k < 12; k++) begin
            int len_r, last_r, mode_r, sel_r, eat_r;
            len_r  = $urandom_range(1, 10);
            last_r = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len_r - 1)) : -1;
            sel_r  = $urandom_range(0, 5);
            mode_r = (sel_r == 4) ? 2 : (sel_r == 5) ? 1 : 0;
            eat_r  = $urandom_range(1, len_r);
            run_cmd($sformatf("rnd%0d", k), AW'($urandom), len_r, last_r,
                    $urandom_range(40, 100), mode_r, eat_r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
